// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU with start/busy/done handshake.
// Build macro SEQ_MULTIPLIER_EARLY_OUT_EN: a zero operand magnitude skips straight to the sign-fix step.
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]        CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0]        CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0]     ZERO_W    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     ONE_W     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0]   ZERO_2W   = {(2*WIDTH){1'b0}};
  localparam logic [2*WIDTH-1:0]   ONE_2W    = {{(2*WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [2*WIDTH-1:0] acc_r, acc_s;
  logic [WIDTH-1:0]   mcand_r, mcand_s;
  logic [WIDTH-1:0]   mplier_r, mplier_s;
  logic [CW-1:0]      cnt_r, cnt_s;
  logic [1:0]         op_r, op_s;
  logic               neg_r, neg_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic [WIDTH-1:0]   result_r, result_s;

  logic               a_signed_s, b_signed_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               neg_in_s;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_s;

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
    if (is_signed && v[WIDTH-1]) begin
      magnitude = ~v + ONE_W;
    end else begin
      magnitude = v;
    end
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v);
    negate_2w = ~v + ONE_2W;
  endfunction

  // Operand signedness per instruction; MUL low word is sign-agnostic.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (op)
      OP_MULH: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
  end

  // Operand magnitudes, product sign, partial-product sum and sign-corrected product.
  always_comb begin
    a_mag_s  = magnitude(a, a_signed_s);
    b_mag_s  = magnitude(b, b_signed_s);
    neg_in_s = (a_signed_s & a[WIDTH-1]) ^ (b_signed_s & b[WIDTH-1]);
    sum_s    = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    if (neg_r) begin
      prod_s = negate_2w(acc_r);
    end else begin
      prod_s = acc_r;
    end
  end

  // Next-state and datapath updates; flush overrides every state.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    cnt_s    = cnt_r;
    op_s     = op_r;
    neg_s    = neg_r;
    done_s   = 1'b0;
    result_s = result_r;
    busy_s   = 1'b0;

    if (flush) begin
      state_s = IDLE;
      cnt_s   = CNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            op_s     = op;
            mcand_s  = a_mag_s;
            mplier_s = b_mag_s;
            neg_s    = neg_in_s;
            acc_s    = ZERO_2W;
            cnt_s    = CNT_ZERO;
`ifdef SEQ_MULTIPLIER_EARLY_OUT_EN
            if ((a_mag_s == ZERO_W) || (b_mag_s == ZERO_W)) begin
              state_s = FIX;
            end else begin
              state_s = CALC;
            end
`else
            state_s  = CALC;
`endif
          end else begin
            state_s = IDLE;
          end
        end
        CALC: begin
          if (mplier_r[0]) begin
            acc_s = {sum_s, acc_r[WIDTH-1:1]};
          end else begin
            acc_s = {1'b0, acc_r[2*WIDTH-1:1]};
          end
          mplier_s = {1'b0, mplier_r[WIDTH-1:1]};
          cnt_s    = cnt_r + CNT_ONE;
          if (cnt_r == LAST_ITER) begin
            state_s = FIX;
          end else begin
            state_s = CALC;
          end
        end
        FIX: begin
          if (op_r == OP_MUL) begin
            result_s = prod_s[WIDTH-1:0];
          end else begin
            result_s = prod_s[2*WIDTH-1:WIDTH];
          end
          done_s  = 1'b1;
          state_s = IDLE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    if (state_s == IDLE) begin
      busy_s = 1'b0;
    end else begin
      busy_s = 1'b1;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      acc_r    <= ZERO_2W;
      mcand_r  <= ZERO_W;
      mplier_r <= ZERO_W;
      cnt_r    <= CNT_ZERO;
      op_r     <= 2'b00;
      neg_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= ZERO_W;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      cnt_r    <= cnt_s;
      op_r     <= op_s;
      neg_r    <= neg_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
      result_r <= result_s;
    end
  end

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier (WIDTH=32): latency-level reference model checked every
// cycle, plus directed operations with hand-computed results. Honors SEQ_MULTIPLIER_EARLY_OUT_EN.
module tb_seq_multiplier;

`ifdef SEQ_MULTIPLIER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_pass = 0;

  seq_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .a(a), .b(b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference product from plain signed arithmetic on 66-bit extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [65:0] ex, ey, p;
    ex = (o == 2'b01 || o == 2'b10) ? $signed({{34{x[31]}}, x}) : $signed({34'd0, x});
    ey = (o == 2'b01) ? $signed({{34{y[31]}}, y}) : $signed({34'd0, y});
    p  = ex * ey;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Latency model: an accepted op completes WIDTH+1 edges later (1 with early-out on zero operand).
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_pend = 32'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_busy = 1'b0; m_done = 1'b0; m_result = 32'd0;
    end else begin
      m_done = 1'b0;
      if (flush) begin
        m_cnt = 0;
      end else if (m_cnt != 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1;
          m_result = m_pend;
        end
      end else if (start) begin
        m_pend = ref_mul(op, a, b);
        m_cnt = (EARLY && (a == 32'd0 || b == 32'd0)) ? 1 : 33;
      end
      m_busy = (m_cnt != 0);
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(posedge clk) begin
    #1;
    check("cyc_busy", 64'(busy), 64'(m_busy));
    check("cyc_done", 64'(done), 64'(m_done));
    check("cyc_result", 64'(result), 64'(m_result));
  end

  task automatic wait_done(output int cyc, output int bcnt);
    cyc = 0;
    bcnt = 0;
    while (cyc < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
    check("done_seen", 64'(done), 64'(1));
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] expv, input string nm);
    int cyc, bc, lat;
    lat = (EARLY && (x == 32'd0 || y == 32'd0)) ? 1 : 33;
    check({nm, "_model"}, 64'(ref_mul(o, x, y)), 64'(expv));
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    wait_done(cyc, bc);
    check({nm, "_latency"}, 64'(cyc), 64'(lat));
    check({nm, "_busycycles"}, 64'(bc), 64'(lat));
    check({nm, "_result"}, 64'(result), 64'(expv));
  endtask

  initial begin
    int cyc, bc, seen;
    logic [31:0] held;

    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Consecutive do_op calls start in the previous done cycle (back-to-back).
    do_op(2'b00, 32'd7, 32'd6, 32'h0000002A, "mul_7x6");
    do_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    do_op(2'b00, 32'h80000000, 32'h80000000, 32'h00000000, "mul_min");
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1");
    do_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    do_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    do_op(2'b00, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, "mul_m1x3");
    do_op(2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, "mulh_m7x6");
    do_op(2'b00, 32'h00000000, 32'h00000005, 32'h00000000, "mul_zero");
    do_op(2'b11, 32'h80000000, 32'h00000002, 32'h00000001, "mulhu_2");

    // Second start at E5 is ignored.
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; op = 2'b11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
    @(negedge clk); start = 1'b0;
    wait_done(cyc, bc);
    check("ignored_latency", 64'(cyc), 64'(28));
    check("ignored_result", 64'(result), 64'h2A);

    // start and flush together in IDLE: request dropped.
    @(negedge clk); start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    check("startflush_busy", 64'(busy), 64'(0));
    @(negedge clk); start = 1'b0; flush = 1'b0;

    // Flush mid-CALC: sampled at E11.
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    held = result;
    flush = 1'b1;
    @(posedge clk); #1;
    check("flush_busy", 64'(busy), 64'(0));
    check("flush_done", 64'(done), 64'(0));
    check("flush_result", 64'(result), 64'(held));
    @(negedge clk); flush = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    check("flush_no_done", 64'(seen), 64'(0));

    // Asynchronous reset mid-CALC clears outputs immediately.
    @(negedge clk); start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_result", 64'(result), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    do_op(2'b00, 32'd3, 32'd5, 32'h0000000F, "mul_after_rst");

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-and-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sits directly downstream of the ripple-carry adder chain in the execute stage. Each cycle it adds one partial product into a double-width accumulator, then returns either the low or the high word to the ALU result mux. It uses a start/busy/done handshake, so the pipeline can stall the execute stage while the product is computed.

## Interface
- `WIDTH`, default 32: operand and result width. Must be ≥ 4.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request. Sampled only in IDLE.
- `flush`  in  1: synchronous abort from pipeline flush. Has priority over `start`.
- `op`  in  2: operation select.
  - 00 MUL (low word)
  - 01 MULH (signed × signed, high word)
  - 10 MULHSU (signed `a` × unsigned `b`, high word)
  - 11 MULHU (unsigned × unsigned, high word)
- `a`  in  WIDTH: multiplicand.
- `b`  in  WIDTH: multiplier.
- `busy`  out  1: high while in CALC or FIX.
- `done`  out  1: one-cycle pulse; `result` is valid in the same cycle.
- `result`  out  WIDTH: selected word. Held until the next accepted start.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - `start`=1 and `flush`=0 → latch `op`; latch |a|, |b| per signedness; latch `neg` = sign(a) XOR sign(b), with only signed operands contributing.
  - Clear the 2·WIDTH accumulator and the iteration counter; go to CALC.
- CALC, once per cycle:
  - If multiplier LSB = 1, add the multiplicand, zero-extended to WIDTH+1 bits, into the accumulator's upper half.
  - Shift the accumulator right by 1; shift the multiplier right by 1.
  - The counter increments; after WIDTH iterations → FIX.
- FIX:
  - If `neg`, the product is replaced by its two's complement, over the full 2·WIDTH bits.
  - `result` = low word for MUL, high word otherwise. Pulse `done`; go to IDLE.
- Magnitude of the most negative value (0x80000000) is taken as an unsigned WIDTH-bit value, 2^(WIDTH−1); no overflow special case is needed.
- `start` while `busy` is ignored: no queueing, and the latched operands are unchanged.
- `flush`=1 in any state → IDLE next edge. `busy`=0; no `done`; `result` keeps its previous value.
- `start` and `flush` in the same IDLE cycle: flush wins, request dropped.
- Async `rst` mid-operation: state IDLE, counter 0, accumulator 0.

## Timing
- Reset values: `busy`=0, `done`=0, `result`=0, state IDLE.
- Start accepted at edge E0.
- `busy` is high from after E0 until after E(WIDTH+1).
- `done` is high for exactly the cycle after edge E(WIDTH+1).
- Latency is WIDTH+1 cycles from the accepting edge to `done`; 33 for WIDTH=32.
- The earliest next start is accepted in the `done` cycle, since the block is already in IDLE. Throughput is one op per WIDTH+2 cycles.
- `result` changes only on the edge that raises `done`.

## Configuration
- Macro `SEQ_MULTIPLIER_EARLY_OUT_EN`.
- Defined: in IDLE, if either latched magnitude is zero, go directly to FIX with a zero accumulator. `done` is high in the cycle after E1, i.e. latency 1. `busy` is high for one cycle.
- Undefined: every operation takes the full WIDTH+1 latency regardless of operand values.
- Results are identical in both builds.

## Test plan
All scenarios use WIDTH=32.
- MUL, a=7, b=6, start at E0 → `done` after E33, `result`=0x0000002A; `busy` high for exactly 33 cycles.
- MULH, a=b=0x80000000 → `result`=0x40000000. MUL with the same operands → 0x00000000. MULH, a=b=0xFFFFFFFF → 0x00000000.
- MULHU, a=b=0xFFFFFFFF → 0xFFFFFFFE. MULHSU, a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFF. MUL, a=0xFFFFFFFF, b=0x00000003 → 0xFFFFFFFD.
- Second `start` with different operands at E5 → ignored; original product delivered at E33. Back-to-back start in the `done` cycle → accepted, next `done` 33 cycles later.
- `flush` at E10 → `busy`=0 after E11, no `done`, `result` unchanged. Async `rst` pulse mid-CALC → all outputs 0 immediately.
- MUL, a=0, b=5:
  - with `SEQ_MULTIPLIER_EARLY_OUT_EN` → `done` after E1, `result`=0.
  - without → `done` after E33, `result`=0.
